// File: rtl/ascon_pkg.sv
// Shared constants, state type and word helpers for the Ascon permutation core.
package ascon_pkg;

    localparam int MAX_ROUNDS = 12;

    // Round constants in the order rounds consume them (ridx 0..11)
    localparam logic [7:0] ASCON_RC [0:MAX_ROUNDS-1] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Linear-layer rotation amounts, two per state word
    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    typedef enum logic {
        IDLE,
        RUN
    } perm_state_e;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Indices past the last round yield a zero constant; those stages are bypassed anyway
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            if (idx == 4'(i)) rc = ASCON_RC[i];
        end
        return rc;
    endfunction

    function automatic logic [63:0] word_x0(input logic [319:0] s);
        return s[319:256];
    endfunction

    function automatic logic [63:0] word_x1(input logic [319:0] s);
        return s[255:192];
    endfunction

    function automatic logic [63:0] word_x2(input logic [319:0] s);
        return s[191:128];
    endfunction

    function automatic logic [63:0] word_x3(input logic [319:0] s);
        return s[127:64];
    endfunction

    function automatic logic [63:0] word_x4(input logic [319:0] s);
        return s[63:0];
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] state_in,
    input  logic [7:0]   rc,
    output logic [319:0] state_out
);

    // Full round evaluated as a sequence of in-place word updates
    always_comb begin : round_logic
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        a0 = word_x0(state_in);
        a1 = word_x1(state_in);
        a2 = word_x2(state_in);
        a3 = word_x3(state_in);
        a4 = word_x4(state_in);

        a2 = a2 ^ {56'h0, rc};

        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        a0 = a0 ^ ror64(a0, ROT_X0_A) ^ ror64(a0, ROT_X0_B);
        a1 = a1 ^ ror64(a1, ROT_X1_A) ^ ror64(a1, ROT_X1_B);
        a2 = a2 ^ ror64(a2, ROT_X2_A) ^ ror64(a2, ROT_X2_B);
        a3 = a3 ^ ror64(a3, ROT_X3_A) ^ ror64(a3, ROT_X3_B);
        a4 = a4 ^ ror64(a4, ROT_X4_A) ^ ror64(a4, ROT_X4_B);

        state_out = {a0, a1, a2, a3, a4};
    end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon p^a core: UNROLL rounds per clock, result held until next start.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         perm_start,
    input  logic [4:0]   rounds,
    input  logic [319:0] S_in,
    output logic [319:0] S_out,
    output logic         perm_ready
);

    perm_state_e  fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [319:0] sout_q, sout_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   ridx_q, ridx_d;
    logic [3:0]   r_clamped;
    logic [3:0]   step;
    logic [319:0] stage [0:UNROLL];

    assign r_clamped = (rounds > 5'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds[3:0];
    assign step      = (cnt_q > 4'(UNROLL)) ? 4'(UNROLL) : cnt_q;
    assign stage[0]  = state_q;

    // Round chain; a stage whose round index is past the remaining count passes its input through
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [3:0]   idx;
        logic [7:0]   rc;
        logic [319:0] rout;

        assign idx = ridx_q + 4'(g);
        assign rc  = round_const(idx);

        ascon_round u_round (
            .state_in (stage[g]),
            .rc       (rc),
            .state_out(rout)
        );

        assign stage[g+1] = (4'(g) < cnt_q) ? rout : stage[g];
    end

    // Next-state logic: accept a start in IDLE, iterate in RUN, publish on the last edge
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        case (fsm_q)
            IDLE: begin
                if (perm_start) begin
                    if (r_clamped == 4'd0) begin
                        sout_d = S_in;
                    end else begin
                        state_d = S_in;
                        cnt_d   = r_clamped;
                        ridx_d  = 4'(MAX_ROUNDS) - r_clamped;
                        fsm_d   = RUN;
                    end
                end
            end
            RUN: begin
                state_d = stage[UNROLL];
                cnt_d   = cnt_q - step;
                ridx_d  = ridx_q + step;
                if (cnt_q == step) begin
                    sout_d = stage[UNROLL];
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Control and published result; reset aborts any run in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm_q  <= IDLE;
            cnt_q  <= 4'd0;
            ridx_q <= 4'd0;
            sout_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            ridx_q <= ridx_d;
            sout_q <= sout_d;
        end
    end

    // Working state needs no reset: it is always loaded on the start edge
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign S_out      = sout_q;
    assign perm_ready = (fsm_q == IDLE);

endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench: UNROLL=1 and UNROLL=4 cores driven in parallel against a golden model.
module tb_ascon_permutation;

    logic         clk;
    logic         resetn;
    logic         perm_start;
    logic [4:0]   rounds;
    logic [319:0] S_in;
    logic [319:0] S_out1, S_out4;
    logic         perm_ready1, perm_ready4;

    int errors;
    int checks;

    typedef struct {
        logic [319:0] s;
        int           cycles;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    localparam logic [319:0] PATTERN = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                        64'h0011223344556677, 64'h8899aabbccddeeff,
                                        64'hdeadbeefcafef00d};
    localparam logic [319:0] INIT_ST = {64'h80400c0600000000, 256'h0};

    ascon_permutation #(.UNROLL(1)) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .perm_start(perm_start),
        .rounds    (rounds),
        .S_in      (S_in),
        .S_out     (S_out1),
        .perm_ready(perm_ready1)
    );

    ascon_permutation #(.UNROLL(4)) dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .perm_start(perm_start),
        .rounds    (rounds),
        .S_in      (S_in),
        .S_out     (S_out4),
        .perm_ready(perm_ready4)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic int clamp_r(input logic [4:0] r);
        return (int'(r) > 12) ? 12 : int'(r);
    endfunction

    // Reference permutation written over a word array
    function automatic logic [319:0] golden_perm(input logic [319:0] s, input logic [4:0] r);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int          n;
        int          ra [5];
        int          rb [5];
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        n = clamp_r(r);
        for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
        for (int i = 12 - n; i < 12; i++) begin
            x[2] ^= {56'h0, 8'hf0 - 8'(15 * i)};
            x[0] ^= x[4];
            x[4] ^= x[3];
            x[2] ^= x[1];
            for (int j = 0; j < 5; j++) t[j] = ~x[j] & x[(j + 1) % 5];
            for (int j = 0; j < 5; j++) x[j] ^= t[(j + 1) % 5];
            x[1] ^= x[0];
            x[0] ^= x[4];
            x[3] ^= x[2];
            x[2] = ~x[2];
            for (int j = 0; j < 5; j++) x[j] = x[j] ^ rot(x[j], ra[j]) ^ rot(x[j], rb[j]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic start_run(input logic [319:0] s, input logic [4:0] r, input bit track);
        exp_t e;
        @(negedge clk);
        perm_start = 1'b1;
        S_in       = s;
        rounds     = r;
        if (track) begin
            e.s      = golden_perm(s, r);
            e.cycles = clamp_r(r);
            q1.push_back(e);
            e.cycles = (clamp_r(r) + 3) / 4;
            q4.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        perm_start = 1'b0;
        S_in       = ~s;
        rounds     = 5'($urandom);
    endtask

    // Called at the negedge after the start edge; pops the scoreboard as each core finishes
    task automatic wait_done(input string tag, input bit poke);
        int   cyc;
        bit   d1, d4;
        exp_t e;
        cyc = 0;
        d1  = 1'b0;
        d4  = 1'b0;
        while (!(d1 && d4) && cyc <= 40) begin
            if (!d1 && perm_ready1) begin
                d1 = 1'b1;
                if (q1.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL %s dut1 unexpected completion: got ready=1 required no result", tag);
                end else begin
                    e = q1.pop_front();
                    checks++;
                    if (cyc !== e.cycles) begin
                        errors++;
                        $display("FAIL %s dut1 busy cycles: got %0d required %0d", tag, cyc, e.cycles);
                    end
                    checks++;
                    if (S_out1 !== e.s) begin
                        errors++;
                        $display("FAIL %s dut1 S_out: got %h required %h", tag, S_out1, e.s);
                    end
                end
            end
            if (!d4 && perm_ready4) begin
                d4 = 1'b1;
                if (q4.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL %s dut4 unexpected completion: got ready=1 required no result", tag);
                end else begin
                    e = q4.pop_front();
                    checks++;
                    if (cyc !== e.cycles) begin
                        errors++;
                        $display("FAIL %s dut4 busy cycles: got %0d required %0d", tag, cyc, e.cycles);
                    end
                    checks++;
                    if (S_out4 !== e.s) begin
                        errors++;
                        $display("FAIL %s dut4 S_out: got %h required %h", tag, S_out4, e.s);
                    end
                end
            end
            if (poke && cyc == 1) begin
                perm_start = 1'b1;
                S_in       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                rounds     = 5'd3;
            end else if (poke && cyc == 2) begin
                perm_start = 1'b0;
            end
            if (!(d1 && d4)) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        if (!(d1 && d4)) begin
            errors++; checks++;
            $display("FAIL %s timeout: got done1=%0b done4=%0b required both 1", tag, d1, d4);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (perm_ready1 !== 1'b1 || perm_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset ready: got %b/%b required 1/1", perm_ready1, perm_ready4);
        end
        checks++;
        if (S_out1 !== '0 || S_out4 !== '0) begin
            errors++;
            $display("FAIL reset S_out: got %h / %h required 0", S_out1, S_out4);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (perm_ready1 !== 1'b1 || perm_ready4 !== 1'b1 || S_out1 !== '0 || S_out4 !== '0) begin
            errors++;
            $display("FAIL reset release: got ready %b/%b S_out %h required ready 1 S_out 0",
                     perm_ready1, perm_ready4, S_out1);
        end
    endtask

    task automatic test_passthrough();
        start_run(PATTERN, 5'd0, 1'b1);
        wait_done("passthrough", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (perm_ready1 !== 1'b1 || perm_ready4 !== 1'b1 || S_out1 !== PATTERN) begin
                errors++;
                $display("FAIL passthrough hold: got ready %b/%b S_out %h required ready 1 S_out %h",
                         perm_ready1, perm_ready4, S_out1, PATTERN);
            end
        end
    endtask

    task automatic test_one_round();
        logic [63:0] x0_exp;
        x0_exp = 64'h4b ^ rot(64'h4b, 19) ^ rot(64'h4b, 28);
        start_run('0, 5'd1, 1'b1);
        wait_done("one_round", 1'b0);
        checks++;
        if (S_out1[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL one_round x4: got %h required 0", S_out1[63:0]);
        end
        checks++;
        if (S_out1[319:256] !== x0_exp) begin
            errors++;
            $display("FAIL one_round x0: got %h required %h", S_out1[319:256], x0_exp);
        end
    endtask

    task automatic test_p12();
        start_run(INIT_ST, 5'd12, 1'b1);
        wait_done("p12_init", 1'b0);
        start_run(PATTERN, 5'd12, 1'b1);
        wait_done("p12_pattern", 1'b0);
    endtask

    task automatic test_partial_and_clamp();
        logic [319:0] p12;
        start_run(PATTERN, 5'd6, 1'b1);
        wait_done("p6", 1'b0);
        start_run(PATTERN, 5'd8, 1'b1);
        wait_done("p8", 1'b0);
        start_run(INIT_ST, 5'd3, 1'b1);
        wait_done("p3", 1'b0);
        p12 = golden_perm(INIT_ST, 5'd12);
        start_run(INIT_ST, 5'd20, 1'b1);
        wait_done("clamp20", 1'b0);
        checks++;
        if (S_out4 !== p12) begin
            errors++;
            $display("FAIL clamp20 vs p12: got %h required %h", S_out4, p12);
        end
    endtask

    task automatic test_busy_ignore();
        logic [319:0] exp_s;
        exp_s = golden_perm(PATTERN, 5'd12);
        start_run(PATTERN, 5'd12, 1'b1);
        wait_done("busy_ignore", 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (perm_ready1 !== 1'b1 || perm_ready4 !== 1'b1 || S_out1 !== exp_s || S_out4 !== exp_s) begin
                errors++;
                $display("FAIL busy_ignore hold: got ready %b/%b S_out1 %h required ready 1 S_out %h",
                         perm_ready1, perm_ready4, S_out1, exp_s);
            end
        end
    endtask

    // Start held high: each core restarts on the edge its ready returns
    task automatic test_back_to_back();
        logic [319:0] vals [0:10];
        logic [319:0] e;
        for (int i = 0; i <= 10; i++)
            vals[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        perm_start = 1'b1;
        rounds     = 5'd4;
        S_in       = vals[0];
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (perm_ready1 !== ((k % 5) == 4)) begin
                errors++;
                $display("FAIL b2b dut1 ready k=%0d: got %b required %b", k, perm_ready1, (k % 5) == 4);
            end
            if ((k % 5) == 4) begin
                e = golden_perm(vals[k-4], 5'd4);
                checks++;
                if (S_out1 !== e) begin
                    errors++;
                    $display("FAIL b2b dut1 S_out k=%0d: got %h required %h", k, S_out1, e);
                end
            end
            checks++;
            if (perm_ready4 !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL b2b dut4 ready k=%0d: got %b required %b", k, perm_ready4, (k % 2) == 1);
            end
            if ((k % 2) == 1) begin
                e = golden_perm(vals[k-1], 5'd4);
                checks++;
                if (S_out4 !== e) begin
                    errors++;
                    $display("FAIL b2b dut4 S_out k=%0d: got %h required %h", k, S_out4, e);
                end
            end
            S_in = vals[k+1];
        end
        perm_start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        start_run(INIT_ST, 5'd12, 1'b0);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (perm_ready1 !== 1'b1 || perm_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL midrun reset ready: got %b/%b required 1/1", perm_ready1, perm_ready4);
        end
        checks++;
        if (S_out1 !== '0 || S_out4 !== '0) begin
            errors++;
            $display("FAIL midrun reset S_out: got %h / %h required 0", S_out1, S_out4);
        end
        resetn = 1'b1;
        start_run(INIT_ST, 5'd12, 1'b1);
        wait_done("after_reset_p12", 1'b0);
    endtask

    initial begin
        clk        = 1'b0;
        resetn     = 1'b0;
        perm_start = 1'b0;
        rounds     = 5'd0;
        S_in       = '0;
        errors     = 0;
        checks     = 0;
        test_reset();
        test_passthrough();
        test_one_round();
        test_p12();
        test_partial_and_clamp();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
